core_bpu: RTL

CORE_BPU -- requirements
Module: core_bpu

---
 rtl/core_bpu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/core_bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters and a
// return-address stack, one-cycle registered prediction, resolution recovery.
module core_bpu #(
   parameter int BTB_DEPTH = 64,
   parameter int RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fetch_valid_i,
   input  logic [31:0]                  fetch_pc_i,
   output logic                         predict_valid_o,
   output logic [31:0]                  predict_pc_o,
   output logic                         taken_o,
   output logic [1:0]                   target_type_o,
   output logic                         dir_type_o,
   output logic                         pc_off_o,
   output logic [$clog2(RAS_DEPTH)-1:0] ras_ptr_o,
   input  logic                         correct_valid_i,
   input  logic                         miss_i,
   input  logic [31:0]                  correct_pc_i,
   input  logic                         true_taken_i,
   input  logic [31:0]                  true_target_i,
   input  logic [1:0]                   true_target_type_i,
   input  logic                         true_conditional_jmp_i,
   input  logic [$clog2(RAS_DEPTH)-1:0] correct_ras_ptr_i,
   input  logic                         ras_miss_type_i
);
   localparam int IW = $clog2(BTB_DEPTH);
   localparam int TW = 30 - IW;
   localparam int PW = $clog2(RAS_DEPTH);
   localparam logic [1:0] TY_NPC  = 2'd0;
   localparam logic [1:0] TY_CALL = 2'd1;
   localparam logic [1:0] TY_RET  = 2'd2;
   localparam logic [1:0] TY_IMM  = 2'd3;
   localparam logic [PW-1:0] ONE = PW'(1);

   logic          btb_v_q   [BTB_DEPTH];
   logic          btb_v_d   [BTB_DEPTH];
   logic [TW-1:0] btb_tag_q [BTB_DEPTH];
   logic [TW-1:0] btb_tag_d [BTB_DEPTH];
   logic [29:0]   btb_tgt_q [BTB_DEPTH];
   logic [29:0]   btb_tgt_d [BTB_DEPTH];
   logic [1:0]    btb_ty_q  [BTB_DEPTH];
   logic [1:0]    btb_ty_d  [BTB_DEPTH];
   logic          btb_cnd_q [BTB_DEPTH];
   logic          btb_cnd_d [BTB_DEPTH];
   logic [1:0]    btb_cnt_q [BTB_DEPTH];
   logic [1:0]    btb_cnt_d [BTB_DEPTH];
   logic [31:0]   ras_q     [RAS_DEPTH];
   logic [31:0]   ras_d     [RAS_DEPTH];
   logic [PW-1:0] ptr_q, ptr_d;

   logic          pv_q, pv_d;
   logic [31:0]   ppc_q, ppc_d;
   logic          tk_q, tk_d;
   logic [1:0]    ty_q, ty_d;
   logic          dir_q, dir_d;
   logic          off_q, off_d;
   logic [PW-1:0] rptr_q, rptr_d;

   logic [IW-1:0] f_idx, c_idx;
   logic          f_hit, c_hit, recover, f_tk;
   logic [1:0]    f_ty, cnt;
   logic [31:0]   f_pc4, f_tgt, f_npc;
   logic          unused_bits;

   assign unused_bits = ^{fetch_pc_i[1:0], correct_pc_i[1:0], true_target_i[1:0]};

   always_comb begin
      btb_v_d   = btb_v_q;
      btb_tag_d = btb_tag_q;
      btb_tgt_d = btb_tgt_q;
      btb_ty_d  = btb_ty_q;
      btb_cnd_d = btb_cnd_q;
      btb_cnt_d = btb_cnt_q;
      ras_d     = ras_q;
      ptr_d     = ptr_q;
      pv_d      = 1'b0;
      ppc_d     = ppc_q;
      tk_d      = tk_q;
      ty_d      = ty_q;
      dir_d     = dir_q;
      off_d     = off_q;
      rptr_d    = rptr_q;
      cnt       = 2'b00;

      recover = correct_valid_i && miss_i;
      f_idx   = fetch_pc_i[IW+1:2];
      f_hit   = btb_v_q[f_idx] && (btb_tag_q[f_idx] == fetch_pc_i[31:IW+2]);
      f_ty    = f_hit ? btb_ty_q[f_idx] : TY_NPC;
      f_pc4   = fetch_pc_i + 32'd4;
      f_tgt   = {btb_tgt_q[f_idx], 2'b00};
      f_tk    = 1'b0;
      f_npc   = f_pc4;
      unique case (f_ty)
         TY_CALL: begin f_tk = 1'b1; f_npc = f_tgt; end
         TY_RET:  begin f_tk = 1'b1; f_npc = ras_q[ptr_q - ONE]; end
         TY_IMM: begin
            f_tk  = btb_cnd_q[f_idx] ? btb_cnt_q[f_idx][1] : 1'b1;
            f_npc = f_tk ? f_tgt : f_pc4;
         end
         default: ;
      endcase

      // A fetch racing a misprediction recovery is dropped entirely.
      if (fetch_valid_i && !recover) begin
         pv_d   = 1'b1;
         ppc_d  = f_npc;
         tk_d   = f_tk;
         ty_d   = f_ty;
         dir_d  = f_hit && btb_cnd_q[f_idx];
         off_d  = fetch_pc_i[2];
         rptr_d = ptr_q;
         if (f_ty == TY_CALL) begin
            ras_d[ptr_q] = f_pc4;
            ptr_d        = ptr_q + ONE;
         end else if (f_ty == TY_RET) begin
            ptr_d = ptr_q - ONE;
         end
      end

      if (recover) begin
         if (ras_miss_type_i) begin
            ptr_d = correct_ras_ptr_i;
            if (true_target_type_i == TY_CALL)
               ras_d[correct_ras_ptr_i - ONE] = correct_pc_i + 32'd4;
         end else if (true_target_type_i == TY_CALL) begin
            ptr_d = correct_ras_ptr_i + ONE;
         end else if (true_target_type_i == TY_RET) begin
            ptr_d = correct_ras_ptr_i - ONE;
         end else begin
            ptr_d = correct_ras_ptr_i;
         end
      end

      c_idx = correct_pc_i[IW+1:2];
      c_hit = btb_v_q[c_idx] && (btb_tag_q[c_idx] == correct_pc_i[31:IW+2]);
      if (correct_valid_i) begin
         if (true_target_type_i == TY_NPC && !true_conditional_jmp_i) begin
            btb_v_d[c_idx] = 1'b0;
         end else begin
            cnt = btb_cnt_q[c_idx];
            if (!c_hit)
               cnt = true_taken_i ? 2'b10 : 2'b01;
            else if (true_conditional_jmp_i && true_taken_i && cnt != 2'b11)
               cnt = cnt + 2'b01;
            else if (true_conditional_jmp_i && !true_taken_i && cnt != 2'b00)
               cnt = cnt - 2'b01;
            btb_v_d[c_idx]   = 1'b1;
            btb_tag_d[c_idx] = correct_pc_i[31:IW+2];
            btb_tgt_d[c_idx] = true_target_i[31:2];
            btb_ty_d[c_idx]  = true_target_type_i;
            btb_cnd_d[c_idx] = true_conditional_jmp_i;
            btb_cnt_d[c_idx] = cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_DEPTH; i++) btb_v_q[i] <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 32'd0;
         ptr_q  <= '0;
         pv_q   <= 1'b0;
         ppc_q  <= 32'd0;
         tk_q   <= 1'b0;
         ty_q   <= 2'b00;
         dir_q  <= 1'b0;
         off_q  <= 1'b0;
         rptr_q <= '0;
      end else begin
         btb_v_q   <= btb_v_d;
         btb_tag_q <= btb_tag_d;
         btb_tgt_q <= btb_tgt_d;
         btb_ty_q  <= btb_ty_d;
         btb_cnd_q <= btb_cnd_d;
         btb_cnt_q <= btb_cnt_d;
         ras_q     <= ras_d;
         ptr_q     <= ptr_d;
         pv_q      <= pv_d;
         ppc_q     <= ppc_d;
         tk_q      <= tk_d;
         ty_q      <= ty_d;
         dir_q     <= dir_d;
         off_q     <= off_d;
         rptr_q    <= rptr_d;
      end
   end

   assign predict_valid_o = pv_q;
   assign predict_pc_o    = ppc_q;
   assign taken_o         = tk_q;
   assign target_type_o   = ty_q;
   assign dir_type_o      = dir_q;
   assign pc_off_o        = off_q;
   assign ras_ptr_o       = rptr_q;
endmodule
